// File: rtl/jtag_scan_master.sv
// JTAG scan master: drives IR/DR scans through the TAP from Run-Test/Idle and back,
// generating TCK as a divided copy of clk and capturing TDO into a right-aligned word.
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_ir,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);

    typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, DONE} state_e;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [5:0] INIT_LAST = 6'd5;

    state_e             state_q, state_d;
    logic [7:0]         div_q, div_d;
    logic               half_q, half_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [5:0]         len_q, len_d;
    logic               ir_q, ir_d;
    logic [MAX_LEN-1:0] data_q, data_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic [MAX_LEN-1:0] cap_q, cap_d;
    logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;

    logic               active;
    logic               rise;
    logic               fall;
    logic               accept;
    logic [5:0]         len_clamped;

    // TMS value to present for period `cnt` of state `st`; bit counts are fixed by the TAP walk.
    function automatic logic tms_for(input state_e st, input logic [5:0] cnt,
                                     input logic ir, input logic [5:0] n);
        case (st)
            INIT:    return cnt < INIT_LAST;
            PRE:     return (cnt == 6'd0) || (ir && (cnt == 6'd1));
            SHIFT:   return cnt == (n - 6'd1);
            POST:    return cnt == 6'd0;
            default: return 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            div_q      <= '0;
            half_q     <= 1'b0;
            cnt_q      <= '0;
            len_q      <= '0;
            ir_q       <= 1'b0;
            data_q     <= '0;
            mask_q     <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            half_q     <= half_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ir_q       <= ir_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
        end
    end

    always_comb begin
        active = (state_q == INIT) || (state_q == PRE) || (state_q == SHIFT) || (state_q == POST);
        rise   = active && !half_q && (div_q == DIV_LAST);
        fall   = active &&  half_q && (div_q == DIV_LAST);
        accept = cmd_valid && (state_q == IDLE);
        if (32'(cmd_len) > MAX_LEN) begin
            len_clamped = 6'(MAX_LEN);
        end else begin
            len_clamped = cmd_len;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ir_d       = ir_q;
        data_d     = data_q;
        mask_d     = mask_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            INIT: begin
                if (fall) begin
                    if (cnt_q == INIT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            IDLE: begin
                if (accept) begin
                    len_d  = len_clamped;
                    ir_d   = cmd_is_ir;
                    data_d = cmd_data;
                    cap_d  = '0;
                    mask_d = MAX_LEN'(1);
                    cnt_d  = '0;
                    if (len_clamped == 6'd0) begin
                        state_d    = DONE;
                        rsp_data_d = '0;
                    end else begin
                        state_d = PRE;
                    end
                end
            end
            PRE: begin
                if (fall) begin
                    if (cnt_q == (ir_q ? 6'd3 : 6'd2)) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            SHIFT: begin
                // One-hot mask walks the capture position, so bits at and above N stay zero.
                if (rise && jtag_tdo) begin
                    cap_d = cap_q | mask_q;
                end
                if (fall) begin
                    data_d = data_q >> 1;
                    mask_d = mask_q << 1;
                    if (cnt_q == (len_q - 6'd1)) begin
                        state_d = POST;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            POST: begin
                if (fall) begin
                    if (cnt_q == 6'd1) begin
                        state_d    = DONE;
                        cnt_d      = '0;
                        rsp_data_d = cap_q;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // TMS/TDI only move on the edge that starts a period (TCK low), keeping them stable at the rise.
    always_comb begin
        div_d  = '0;
        half_d = 1'b0;
        tck_d  = tck_q;
        tms_d  = tms_q;
        tdi_d  = tdi_q;
        if (active) begin
            div_d  = (div_q == DIV_LAST) ? '0 : div_q + 8'd1;
            half_d = (div_q == DIV_LAST) ? !half_q : half_q;
        end
        if (rise) begin
            tck_d = 1'b1;
        end
        if (fall) begin
            tck_d = 1'b0;
        end
        if (fall || accept) begin
            tms_d = tms_for(state_d, cnt_d, ir_d, len_d);
            tdi_d = (state_d == SHIFT) ? data_d[0] : 1'b0;
        end
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        rsp_valid = (state_q == DONE);
        rsp_data  = rsp_data_q;
        jtag_tck  = tck_q;
        jtag_tms  = tms_q;
        jtag_tdi  = tdi_q;
    end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: directed scans against a one-bit TAP data model,
// responses checked by a scoreboard monitor decoupled from the stimulus.
module tb_jtag_scan_master;

    localparam int MAX_LEN = 32;
    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_is_ir = 1'b0;
    logic [5:0]  cmd_len = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;
    logic        jtag_tck;
    logic        jtag_tms;
    logic        jtag_tdi;
    logic        jtag_tdo;

    always #5 clk = ~clk;

    jtag_scan_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_is_ir (cmd_is_ir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .jtag_tck  (jtag_tck),
        .jtag_tms  (jtag_tms),
        .jtag_tdi  (jtag_tdi),
        .jtag_tdo  (jtag_tdo)
    );

    // Target model: 0 = TDI looped back one period late, 1 = TDO high, 2 = TDO low.
    logic [1:0] tdo_mode = 2'd0;
    logic       tap_r = 1'b0;
    logic       tdo_lb = 1'b0;
    always @(posedge jtag_tck) tap_r <= jtag_tdi;
    always @(negedge jtag_tck) tdo_lb <= tap_r;
    assign jtag_tdo = (tdo_mode == 2'd1) ? 1'b1 : ((tdo_mode == 2'd0) ? tdo_lb : 1'b0);

    typedef struct {
        string       name;
        logic [31:0] data;
        int          pulses;
        logic [63:0] tms;
        logic [63:0] tdi;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_pass = 0;
    int          n_total = 0;
    int          obs_pulses = 0;
    int          lat = 0;
    logic [63:0] obs_tms = '0;
    logic [63:0] obs_tdi = '0;
    logic        prev_tck = 1'b0;

    function automatic exp_t mk(input string name, input logic [31:0] data, input int pulses,
                                input logic [63:0] tms, input logic [63:0] tdi, input int l);
        exp_t e;
        e.name = name; e.data = data; e.pulses = pulses;
        e.tms = tms; e.tdi = tdi; e.lat = l;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: records TCK pulses since the last accept and scores every rsp_valid.
    always @(negedge clk) begin
        if (reset) begin
            obs_pulses = 0; obs_tms = '0; obs_tdi = '0; lat = 0;
        end else begin
            lat++;
            if (cmd_valid && cmd_ready) begin
                obs_pulses = 0; obs_tms = '0; obs_tdi = '0; lat = 0;
            end
            if (jtag_tck && !prev_tck) begin
                if (obs_pulses < 64) begin
                    obs_tms = obs_tms | (64'(jtag_tms) << obs_pulses);
                    obs_tdi = obs_tdi | (64'(jtag_tdi) << obs_pulses);
                end
                obs_pulses++;
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_rsp: got rsp_valid with rsp_data 0x%0h, expected none", rsp_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_data"},    64'(rsp_data),   64'(mon_e.data));
                    chk({mon_e.name, "_pulses"},  64'(obs_pulses), 64'(mon_e.pulses));
                    chk({mon_e.name, "_tms"},     obs_tms,         mon_e.tms);
                    chk({mon_e.name, "_tdi"},     obs_tdi,         mon_e.tdi);
                    chk({mon_e.name, "_latency"}, 64'(lat),        64'(mon_e.lat));
                end
            end
        end
        prev_tck = jtag_tck;
    end

    task automatic send(input logic ir, input logic [5:0] len, input logic [31:0] data,
                        input bit push, input exp_t e);
        int k = 0;
        while (!cmd_ready && k < 2000) begin
            @(posedge clk); #1; k++;
        end
        if (!cmd_ready) begin
            n_total++;
            $display("FAIL %s_ready_timeout: got cmd_ready 0, expected 1", e.name);
            return;
        end
        cmd_is_ir = ir; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = data ^ 32'h5A5A_5A5A;
        cmd_len   = ~len;
        cmd_is_ir = ~ir;
    endtask

    task automatic wait_rsp(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 3000) begin
            @(posedge clk); #1; k++;
        end
        n_total++;
        if (sb.size() == 0) n_pass++;
        else begin
            $display("FAIL %s_rsp_timeout: got %0d pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_reset_pins"}, 64'({jtag_tck, jtag_tms, jtag_tdi, rsp_valid, cmd_ready, busy}), 64'b010001);
        chk({tag, "_reset_rsp_data"}, 64'(rsp_data), 64'd0);
    endtask

    task automatic check_init(input string tag);
        int cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!cmd_ready && cyc < 200);
        chk({tag, "_ready_cycles"}, 64'(cyc), 64'd24);
        chk({tag, "_init_pulses"}, 64'(obs_pulses), 64'd6);
        chk({tag, "_init_tms"}, obs_tms, 64'h1F);
    endtask

    initial begin
        exp_t none;
        none = mk("abort", '0, 0, '0, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        reset = 1'b0;
        check_init("por");

        // DR 8 bits, loopback: captured word is the data shifted up one place.
        tdo_mode = 2'd0;
        send(1'b0, 6'd8, 32'h0000_00A5, 1'b1, mk("dr8", 32'h0000_004A, 13, 64'hC01, 64'h528, 53));
        repeat (10) @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_len = 6'd3; cmd_data = 32'h7;
        repeat (8) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_rsp("dr8");
        repeat (5) @(posedge clk);
        #1;
        chk("dr8_hold", 64'(rsp_data), 64'h4A);

        tdo_mode = 2'd1;
        send(1'b1, 6'd4, 32'h0000_000C, 1'b1, mk("ir4", 32'h0000_000F, 10, 64'h183, 64'hC0, 41));
        wait_rsp("ir4");

        tdo_mode = 2'd2;
        send(1'b0, 6'd0, 32'hFFFF_FFFF, 1'b1, mk("len0", 32'h0, 0, 64'h0, 64'h0, 1));
        wait_rsp("len0");

        tdo_mode = 2'd0;
        send(1'b0, 6'd40, 32'hDEAD_BEEF, 1'b1,
             mk("len40", 32'hBD5B_7DDE, 37, 64'h0000_000C_0000_0001, 64'h0000_0006_F56D_F778, 149));
        wait_rsp("len40");

        // Abort a 16-bit DR scan during shift bit 3.
        send(1'b0, 6'd16, 32'h1234_5678, 1'b0, none);
        begin
            int k = 0;
            while (obs_pulses < 7 && k < 500) begin
                @(posedge clk); #1; k++;
            end
        end
        chk("abort_bit3_reached", 64'(obs_pulses), 64'd7);
        reset = 1'b1;
        #1;
        check_reset("abort");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_init("abort");
        repeat (60) @(posedge clk);
        #1;
        chk("abort_no_rsp", 64'(sb.size()), 64'd0);

        send(1'b0, 6'd4, 32'h0000_0003, 1'b1, mk("dr4", 32'h0000_0006, 9, 64'hC1, 64'h18, 37));
        wait_rsp("dr4");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jtag_scan_master.md
JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 Parameter: MAX_LEN, default 32, maximum shift length in bits; sets the width of cmd_data and rsp_data.
REQ-002 Parameter: CLK_DIV, default 2, clk cycles per TCK half-period; legal range 1..255.
REQ-003 Port: clk, input, 1, system clock; the only clock; all state on its rising edge.
REQ-004 Port: reset, input, 1, asynchronous, active-high reset.
REQ-005 Port: cmd_valid, input, 1, scan command present.
REQ-006 Port: cmd_ready, output, 1, block can accept a command.
REQ-007 Port: cmd_is_ir, input, 1, 1 = IR scan, 0 = DR scan.
REQ-008 Port: cmd_len, input, 6, number of bits to shift.
REQ-009 Port: cmd_data, input, MAX_LEN, TDI bits, LSB shifted first.
REQ-010 Port: rsp_valid, output, 1, one-cycle pulse marking a completed scan.
REQ-011 Port: rsp_data, output, MAX_LEN, captured TDO bits, right-aligned, LSB first.
REQ-012 Port: busy, output, 1, high from command accept (or reset init) until rsp_valid (or init end).
REQ-013 Port: jtag_tck, output, 1, generated test clock to target chain.
REQ-014 Port: jtag_tms, output, 1, TAP mode select to target.
REQ-015 Port: jtag_tdi, output, 1, serial data to target chain.
REQ-016 Port: jtag_tdo, input, 1, serial data from target chain; synchronous to jtag_tck.

Function
REQ-017 TCK generation: each TCK period SHALL be 2*CLK_DIV clk cycles, low half then high half; TCK idles low between periods.
REQ-018 jtag_tms and jtag_tdi SHALL change only on the clk edge that drives TCK low; they are stable across the rising edge.
REQ-019 jtag_tdo SHALL be sampled on the clk edge that drives TCK high, and only during Shift-state periods.
REQ-020 Command handshake: a transfer occurs when cmd_valid && cmd_ready on a clk edge; cmd_ready = !busy.
REQ-021 Command fields SHALL be latched on accept; later input changes have no effect on the scan in progress.
REQ-022 FSM states: INIT, IDLE, PRE, SHIFT, POST, DONE.
REQ-023 INIT: 5 TCK periods with TMS=1, then 1 with TMS=0; target ends in Run-Test/Idle; then go to IDLE.
REQ-024 IDLE: TCK low, TMS=0, TDI=0; on accept go to PRE.
REQ-025 PRE for DR: TMS sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR).
REQ-026 PRE for IR: TMS sequence 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
REQ-027 SHIFT: N periods, TDI = cmd_data[i] in period i; TMS=0 except the last period, where TMS=1 (Exit1).
REQ-028 POST: TMS sequence 1,0 (Update, Run-Test/Idle).
REQ-029 DONE: rsp_valid pulses for exactly one clk; FSM returns to IDLE on the same edge.
REQ-030 TCK period counts: DR scan = N+5, IR scan = N+6, INIT = 6.
REQ-031 rsp_data[i] SHALL equal the TDO sampled in shift period i; bits at and above N SHALL be 0.
REQ-032 rsp_data SHALL hold its value until the next rsp_valid.
REQ-033 cmd_len=0: no TCK pulses; rsp_valid pulses the clk after accept with rsp_data=0.
REQ-034 cmd_len > MAX_LEN: clamp N to MAX_LEN.
REQ-035 cmd_valid while busy SHALL be ignored; the command is not queued.

Reset
REQ-036 While reset is high: jtag_tck=0, jtag_tms=1, jtag_tdi=0, rsp_valid=0, rsp_data=0, cmd_ready=0, busy=1, FSM=INIT with counters cleared.
REQ-037 On reset deassert, INIT SHALL run; cmd_ready rises only after INIT completes.
REQ-038 Reset asserted mid-scan: scan aborts immediately; no rsp_valid; INIT re-runs after deassert.

Verification
REQ-039 Reset release, CLK_DIV=2: 6 TCK pulses with TMS 1,1,1,1,1,0; cmd_ready rises after 24 clk cycles.
REQ-040 DR scan, len=8, data=0xA5, TDO loopback of TDI delayed one period: 13 TCK pulses; TDI sequence 1,0,1,0,0,1,0,1; TMS=1 only on the 8th shift period; rsp_data correct.
REQ-041 IR scan, len=4, data=0xC, TDO tied high: TMS 1,1,0,0,0,0,0,1,1,0; rsp_data=0x0000000F.
REQ-042 len=0 command: zero TCK edges; rsp_valid one clk after accept with rsp_data=0.
REQ-043 len=40 with MAX_LEN=32: 37 TCK pulses; rsp_data holds 32 captured bits.
REQ-044 Reset pulse at shift bit 3 of a 16-bit DR scan: outputs take reset values; no rsp_valid; INIT sequence observed after release.
